// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and a helper that classifies signed operations.
package mips_pkg;

  localparam int MDU_OP_W = 3;

  localparam logic [MDU_OP_W-1:0] MDU_MULT  = 3'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULTU = 3'd1;
  localparam logic [MDU_OP_W-1:0] MDU_DIV   = 3'd2;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 3'd3;
  localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 3'd4;
  localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

  function automatic logic isSignedOp(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the register-file stage and the multiply/divide unit.
interface mul_div_unit_if
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic                Start;
  logic [MDU_OP_W-1:0] Op;
  logic [WIDTH-1:0]    SrcA;
  logic [WIDTH-1:0]    SrcB;
  logic                Busy;
  logic                Done;
  logic [WIDTH-1:0]    HI;
  logic [WIDTH-1:0]    LO;

  modport master (
    output Start, Op, SrcA, SrcB,
    input  Busy, Done, HI, LO
  );

  modport slave (
    input  Start, Op, SrcA, SrcB,
    output Busy, Done, HI, LO
  );

endinterface

// File: rtl/mul_div_unit_abs_neg.sv
// Combinational conditional two's-complement negate, used both to take operand
// magnitudes and to restore result signs.
module mdu_abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_value
);

  assign o_value = i_neg ? -i_value : i_value;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply and restoring
// divide on magnitudes, one bit per cycle, with sign correction in a final cycle.
module mul_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_t r_state;
  mdu_state_t w_nextState;

  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_accHi;
  logic [WIDTH-1:0]   r_accLo;
  logic [WIDTH:0]     r_opA;
  logic [WIDTH:0]     r_opB;
  logic               r_isMul;
  logic               r_negQ;
  logic               r_negR;
  logic               r_divZero;
  logic               r_done;
  logic [WIDTH-1:0]   r_hiOut;
  logic [WIDTH-1:0]   r_loOut;

  logic               w_accept;
  logic               w_isMul;
  logic               w_isMulDiv;
  logic               w_signedOp;
  logic               w_signA;
  logic               w_signB;
  logic               w_lastIter;
  logic [WIDTH:0]     w_extA;
  logic [WIDTH:0]     w_extB;
  logic [WIDTH:0]     w_magA;
  logic [WIDTH:0]     w_magB;
  logic [WIDTH:0]     w_mulSum;
  logic [WIDTH:0]     w_divShift;
  logic [WIDTH-1:0]   w_divDiff;
  logic               w_divGeq;
  logic [2*WIDTH-1:0] w_prodFix;
  logic [WIDTH-1:0]   w_quotFix;
  logic [WIDTH-1:0]   w_remFix;

  assign w_isMul    = (bus.Op == MDU_MULT) || (bus.Op == MDU_MULTU);
  assign w_isMulDiv = w_isMul || (bus.Op == MDU_DIV) || (bus.Op == MDU_DIVU);
  assign w_signedOp = isSignedOp(bus.Op);
  assign w_signA    = w_signedOp & bus.SrcA[WIDTH-1];
  assign w_signB    = w_signedOp & bus.SrcB[WIDTH-1];
  assign w_lastIter = (r_cnt == CW'(WIDTH - 1));

  // Operands widen by one bit so the magnitude of the most negative value is exact.
  assign w_extA = {w_signA, bus.SrcA};
  assign w_extB = {w_signB, bus.SrcB};

  mdu_abs_neg #(.WIDTH(WIDTH + 1)) u_absA (.i_value(w_extA), .i_neg(w_signA), .o_value(w_magA));
  mdu_abs_neg #(.WIDTH(WIDTH + 1)) u_absB (.i_value(w_extB), .i_neg(w_signB), .o_value(w_magB));

  assign w_mulSum   = {1'b0, r_accHi} + (r_accLo[0] ? r_opA : '0);
  assign w_divShift = {r_accHi, r_accLo[WIDTH-1]};
  assign w_divGeq   = (w_divShift >= r_opB);
  assign w_divDiff  = w_divShift[WIDTH-1:0] - r_opB[WIDTH-1:0];

  mdu_abs_neg #(.WIDTH(2 * WIDTH)) u_prodFix (.i_value({r_accHi, r_accLo}), .i_neg(r_negQ), .o_value(w_prodFix));
  mdu_abs_neg #(.WIDTH(WIDTH))     u_quotFix (.i_value(r_accLo), .i_neg(r_negQ), .o_value(w_quotFix));
  mdu_abs_neg #(.WIDTH(WIDTH))     u_remFix  (.i_value(r_accHi), .i_neg(r_negR), .o_value(w_remFix));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: if (bus.Start && w_isMulDiv) begin
        w_accept    = 1'b1;
        w_nextState = ITER;
      end
      ITER:    if (w_lastIter) w_nextState = FIX;
      FIX:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Accumulator holds partial product high / partial remainder; the low word
  // shifts out multiplier bits or shifts in quotient bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_accHi   <= '0;
      r_accLo   <= '0;
      r_opA     <= '0;
      r_opB     <= '0;
      r_isMul   <= 1'b0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_divZero <= 1'b0;
      r_done    <= 1'b0;
      r_hiOut   <= '0;
      r_loOut   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_cnt     <= '0;
        r_opA     <= w_magA;
        r_opB     <= w_magB;
        r_isMul   <= w_isMul;
        r_negQ    <= w_signA ^ w_signB;
        r_negR    <= w_signA;
        r_divZero <= (bus.SrcB == '0);
        r_accHi   <= '0;
        r_accLo   <= w_isMul ? w_magB[WIDTH-1:0] : w_magA[WIDTH-1:0];
      end else if (r_state == ITER) begin
        r_cnt <= r_cnt + CW'(1);
        if (r_isMul) begin
          r_accHi <= w_mulSum[WIDTH:1];
          r_accLo <= {w_mulSum[0], r_accLo[WIDTH-1:1]};
        end else begin
          r_accHi <= w_divGeq ? w_divDiff : w_divShift[WIDTH-1:0];
          r_accLo <= {r_accLo[WIDTH-2:0], w_divGeq};
        end
      end else if (r_state == FIX) begin
        r_done <= 1'b1;
        if (r_isMul) begin
          {r_hiOut, r_loOut} <= w_prodFix;
        end else begin
          // A zero divisor leaves the dividend in the remainder; only LO needs forcing.
          r_hiOut <= w_remFix;
          r_loOut <= r_divZero ? '1 : w_quotFix;
        end
      end else if (r_state == IDLE && bus.Start) begin
        if (bus.Op == MDU_MTHI) r_hiOut <= bus.SrcA;
        if (bus.Op == MDU_MTLO) r_loOut <= bus.SrcA;
      end
    end
  end

  assign bus.Busy = (r_state != IDLE);
  assign bus.Done = r_done;
  assign bus.HI   = r_hiOut;
  assign bus.LO   = r_loOut;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed results, latency, Busy width,
// ignored requests while busy, MTHI/MTLO and mid-operation reset.
module tb_mul_div_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   nVectors = 0;
  int   nMiscompares = 0;
  int   edgesSinceStart = 0;
  int   busyCount = 0;

  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nVectors++;
    assert (observed === expected)
    else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one edge and sample 1 ns later, tracking edges and Busy since accept.
  task automatic stepCycle();
    @(posedge clk);
    #1;
    edgesSinceStart++;
    if (bus.Busy) busyCount++;
  endtask

  task automatic injectStart(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.SrcA  = a;
    bus.SrcB  = b;
    stepCycle();
    bus.Start = 1'b0;
    bus.SrcA  = 32'hDEAD_BEEF;
    bus.SrcB  = 32'h0BAD_F00D;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    injectStart(op, a, b);
    edgesSinceStart = 0;
    busyCount = bus.Busy ? 1 : 0;
  endtask

  task automatic waitDone();
    for (int i = 0; i < 40; i++) begin
      if (bus.Done) break;
      stepCycle();
    end
  endtask

  task automatic runAndCheck(input string tag, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo);
    applyStimulus(op, a, b);
    waitDone();
    checkOutput({tag, "_latency"}, 32'(edgesSinceStart), 32'd33);
    checkOutput({tag, "_busy"}, 32'(busyCount), 32'd33);
    checkOutput({tag, "_hi"}, bus.HI, expHi);
    checkOutput({tag, "_lo"}, bus.LO, expLo);
    stepCycle();
    checkOutput({tag, "_donePulse"}, 32'(bus.Done), 32'd0);
    checkOutput({tag, "_idle"}, 32'(bus.Busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.Start = 1'b0;
    bus.Op    = MDU_MULT;
    bus.SrcA  = '0;
    bus.SrcB  = '0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_busy", 32'(bus.Busy), 32'd0);
    checkOutput("reset_done", 32'(bus.Done), 32'd0);
    checkOutput("reset_hi", bus.HI, 32'd0);
    checkOutput("reset_lo", bus.LO, 32'd0);

    runAndCheck("mult_neg2x3", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    runAndCheck("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    runAndCheck("mult_minxmin", MDU_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    runAndCheck("div_m7d2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runAndCheck("divu_7d2", MDU_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
    runAndCheck("div_100dm7", MDU_DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2);
    runAndCheck("divu_maxd16", MDU_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 32'h0FFF_FFFF);
    runAndCheck("div_byzero", MDU_DIV, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
    runAndCheck("div_negbyzero", MDU_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    runAndCheck("div_overflow", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    applyStimulus(MDU_MTLO, 32'hCAFE_F00D, 32'd0);
    checkOutput("mtlo_lo", bus.LO, 32'hCAFE_F00D);
    checkOutput("mtlo_hi", bus.HI, 32'd0);
    checkOutput("mtlo_busy", 32'(bus.Busy), 32'd0);
    checkOutput("mtlo_done", 32'(bus.Done), 32'd0);

    applyStimulus(MDU_MTHI, 32'h1111_1111, 32'd0);
    checkOutput("mthi_hi", bus.HI, 32'h1111_1111);
    checkOutput("mthi_lo", bus.LO, 32'hCAFE_F00D);
    checkOutput("mthi_done", 32'(bus.Done), 32'd0);

    // Requests arriving while busy must neither disturb HI/LO nor be queued.
    applyStimulus(MDU_MULTU, 32'd3, 32'd4);
    repeat (3) stepCycle();
    injectStart(MDU_MTHI, 32'h5555_5555, 32'd0);
    checkOutput("busy_mthi_hi", bus.HI, 32'h1111_1111);
    checkOutput("busy_mthi_lo", bus.LO, 32'hCAFE_F00D);
    injectStart(MDU_MULT, 32'd7, 32'd7);
    waitDone();
    checkOutput("busy_ign_latency", 32'(edgesSinceStart), 32'd33);
    checkOutput("busy_ign_hi", bus.HI, 32'd0);
    checkOutput("busy_ign_lo", bus.LO, 32'd12);
    stepCycle();
    checkOutput("busy_ign_noqueue", 32'(bus.Busy), 32'd0);
    checkOutput("busy_ign_donePulse", 32'(bus.Done), 32'd0);

    applyStimulus(MDU_DIV, 32'd100, 32'd7);
    repeat (9) stepCycle();
    @(negedge clk);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("abort_busy", 32'(bus.Busy), 32'd0);
    checkOutput("abort_done", 32'(bus.Done), 32'd0);
    checkOutput("abort_hi", bus.HI, 32'd0);
    checkOutput("abort_lo", bus.LO, 32'd0);
    runAndCheck("after_abort_divu", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
